// File: rtl/led_cmd_ctrl.sv
// UART byte-stream LED command controller: single/two-byte ASCII commands drive NUM_LEDS outputs.
// Optional per-LED blink hardware is built only when LED_BLINK_EN is defined.
module led_cmd_ctrl #(
  parameter int NUM_LEDS       = 10,
  parameter int BLINK_DIV      = 25_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                cmd_ack,
  output logic                cmd_err,
  output logic                busy
);

  if (NUM_LEDS < 1 || NUM_LEDS > 16) begin : g_bad_num_leds
    $error("led_cmd_ctrl: NUM_LEDS must be 1..16");
  end
  if (BLINK_DIV < 2) begin : g_bad_blink_div
    $error("led_cmd_ctrl: BLINK_DIV must be >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("led_cmd_ctrl: TIMEOUT_CYCLES must be >= 1");
  end

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_IDX} fsm_t;
  typedef enum logic [1:0] {OP_S, OP_C, OP_T, OP_B} op_t;

  fsm_t                fsm_q, fsm_d;
  op_t                 op_q, op_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [NUM_LEDS-1:0] state_q, state_d;
  logic [NUM_LEDS-1:0] blink_q, blink_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [4:0]          hex;

  // Returns {valid, value} for an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)      return {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
    else                               return 5'b0;
  endfunction

  always_comb begin
    fsm_d   = fsm_q;
    op_d    = op_q;
    tcnt_d  = tcnt_q;
    state_d = state_q;
    blink_d = blink_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    hex     = hex_decode(rx_data);
    unique case (fsm_q)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            8'h31: begin state_d[0] = 1'b1; blink_d[0] = 1'b0; ack_d = 1'b1; end
            8'h30: begin state_d[0] = 1'b0; blink_d[0] = 1'b0; ack_d = 1'b1; end
            8'h41: begin state_d = '1; blink_d = '0; ack_d = 1'b1; end
            8'h5A: begin state_d = '0; blink_d = '0; ack_d = 1'b1; end
            8'h53: begin op_d = OP_S; fsm_d = WAIT_IDX; tcnt_d = '0; end
            8'h43: begin op_d = OP_C; fsm_d = WAIT_IDX; tcnt_d = '0; end
            8'h54: begin op_d = OP_T; fsm_d = WAIT_IDX; tcnt_d = '0; end
`ifdef LED_BLINK_EN
            8'h42: begin op_d = OP_B; fsm_d = WAIT_IDX; tcnt_d = '0; end
`endif
            8'h0D, 8'h0A, 8'h20: ;
            default: err_d = 1'b1;
          endcase
        end
      end
      WAIT_IDX: begin
        if (rx_valid) begin
          fsm_d = IDLE;
          if (!hex[4] || int'(hex[3:0]) >= NUM_LEDS) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) begin
              if (hex[3:0] == 4'(i)) begin
                unique case (op_q)
                  OP_S: begin state_d[i] = 1'b1;        blink_d[i] = 1'b0; end
                  OP_C: begin state_d[i] = 1'b0;        blink_d[i] = 1'b0; end
                  OP_T: begin state_d[i] = ~state_q[i]; blink_d[i] = 1'b0; end
                  OP_B: blink_d[i] = 1'b1;
                endcase
              end
            end
          end
        end else if (tcnt_q == TO_LAST) begin
          // A byte arriving on the expiry cycle wins over the timeout.
          err_d = 1'b1;
          fsm_d = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      op_q    <= OP_S;
      tcnt_q  <= '0;
      state_q <= '0;
      blink_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      op_q    <= op_d;
      tcnt_q  <= tcnt_d;
      state_q <= state_d;
      blink_q <= blink_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

`ifdef LED_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  // Free-running phase generator shared by all blinking LEDs.
  always_comb begin
    bcnt_d  = bcnt_q + 1'b1;
    phase_d = phase_q;
    if (bcnt_q == BLINK_LAST) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign led_out = (blink_q & {NUM_LEDS{phase_q}}) | (~blink_q & state_q);
`else
  assign led_out = state_q;
`endif

  assign cmd_ack = ack_q;
  assign cmd_err = err_q;
  assign busy    = (fsm_q == WAIT_IDX);

endmodule

// File: doc/led_cmd_ctrl.md
# led_cmd_ctrl

Parametrised UART-driven LED command controller: consumes bytes from the UART receiver, parses single- and two-byte ASCII commands, and drives up to 16 LEDs with set, clear, toggle, all-on/all-off and per-LED blink. It sits between the UART receiver and the board LED pins. It keeps the legacy '1'/'0' control of LED 0 and adds command acknowledge/error status and an inter-byte timeout.

## Interface
- NUM_LEDS, 10, number of driven LEDs; legal range 1..16
- BLINK_DIV, 25_000_000, clock cycles per blink phase half-period; must be ≥ 2
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between opcode and index byte; must be ≥ 1
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  byte from UART receiver
- rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
- led_out  output  NUM_LEDS  LED drive, bit i = LED i
- cmd_ack  output  1  one-cycle pulse: command executed
- cmd_err  output  1  one-cycle pulse: command rejected or timed out
- busy  output  1  high while waiting for an index byte

## Operation
- Internal state: state[NUM_LEDS-1:0], blink_en[NUM_LEDS-1:0], blink phase bit, blink counter, timeout counter, latched opcode.
- led_out[i] = blink_en[i] ? phase : state[i].
- FSM states: IDLE, WAIT_IDX.
- IDLE, rx_valid with:
  - '1' (0x31): state[0]=1, blink_en[0]=0, ack.
  - '0' (0x30): state[0]=0, blink_en[0]=0, ack.
  - 'A' (0x41): all state=1, all blink_en=0, ack.
  - 'Z' (0x5A): all state=0, all blink_en=0, ack.
  - 'S','C','T','B' (0x53,0x43,0x54,0x42): latch opcode, go WAIT_IDX, clear timeout counter; no pulse.
  - 0x0D, 0x0A, 0x20: ignored, no pulse.
  - anything else: err.
- WAIT_IDX, rx_valid: index = hex digit ('0'-'9', 'A'-'F', 'a'-'f'). Non-hex or index ≥ NUM_LEDS → err. Otherwise execute, then ack:
  - S: state[idx]=1, blink_en[idx]=0.
  - C: state[idx]=0, blink_en[idx]=0.
  - T: state[idx]=~state[idx], blink_en[idx]=0.
  - B: blink_en[idx]=1; state unchanged.
  - Always return to IDLE.
- WAIT_IDX, no rx_valid: counter increments. When it reaches TIMEOUT_CYCLES → err, IDLE. An rx_valid in that same cycle takes priority over timeout.
- Blink counter free-runs 0..BLINK_DIV-1; on wrap, phase toggles. The counter runs regardless of blink_en.
- busy = (state == WAIT_IDX).

## Timing
- Reset: led_out=0, state=0, blink_en=0, phase=0, counters=0, FSM=IDLE, cmd_ack=0, cmd_err=0, busy=0.
- Latency: byte with rx_valid at edge n → led_out and ack/err change at edge n+1 (registered outputs, 1 cycle).
- ack and err are never high together; each is high for exactly one cycle per command.
- Back-to-back rx_valid on consecutive cycles is fully supported; no back-pressure.
- Timeout: opcode accepted at edge n, no further bytes → cmd_err high after edge n+TIMEOUT_CYCLES.
- Phase period: 2×BLINK_DIV cycles; first toggle BLINK_DIV cycles after reset release.
- rst asserted mid-command discards the latched opcode. rst has priority over rx_valid.

## Configuration
- LED_BLINK_EN defined: blink counter, phase and blink_en logic present as described.
- Not defined: no blink hardware. 'B' in IDLE → cmd_err, stays IDLE. blink_en is constant 0 and led_out = state.

## Test plan
- Reset then '1' → led_out[0]=1 and cmd_ack one cycle later; '0' → led_out[0]=0, ack.
- NUM_LEDS=10: 'S','7' → led_out=0x080 and ack; 'T','7' → 0x000; 'A' → 0x3FF; 'Z' → 0x000.
- 'S','C' (index 12 ≥ 10) → cmd_err, led_out unchanged; 'Q' → err; 0x0D → neither pulse.
- TIMEOUT_CYCLES=8: 'C' then idle → busy high for 8 cycles, then cmd_err pulse, busy=0; following '1' is accepted.
- LED_BLINK_EN, BLINK_DIV=4: 'B','2' → led_out[2] toggles every 4 cycles; 'S','2' → steady 1.
- 'S' then rst mid-command then '3' → '3' decoded in IDLE as error; led_out=0.
